ber_test_sequencer: RTL and testbench
=====================================

BER_TEST_SEQUENCER -- requirements
Module: ber_test_sequencer

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 4: number of cycles the datapath chain is held in reset.
REQ-002 SHALL have parameter WARMUP_CYCLES, default 8: number of cycles the chain runs before measurement, covering pipeline and DFE fill.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536: maximum number of MEASURE cycles before forced stop.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a test; sampled in IDLE only.
REQ-007 abort  input  1  cancels the test in progress from any state.
REQ-008 meas_bits  input  32  number of checked bits to measure; sampled on an accepted start.
REQ-009 err_limit  input  32  early-stop error threshold, 0 = disabled; sampled on an accepted start.
REQ-010 total_bits  input  32  cumulative bit count from the prbs31_checker.
REQ-011 total_bit_errors  input  32  cumulative error count from the checker.
REQ-012 chain_rstn  output  1  active-low reset driven to prbs/encode/channel/DFE/checker.
REQ-013 chain_en  output  1  enable driven to prbs31 and noise.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse when results are latched.
REQ-016 result_bits, result_errors  output  32 each  measured deltas.
REQ-017 result_valid  output  1  high while the result registers hold a completed test.
REQ-018 status  output  2  00 = ok, 01 = early_stop, 10 = timeout, 11 = aborted.

Function
REQ-019 SHALL implement states IDLE, FLUSH, WARMUP, MEASURE and DONE; all outputs SHALL be registered.
REQ-020 IDLE: a start sampled high with abort low SHALL move to FLUSH on the next edge, latch meas_bits and err_limit, and clear result_valid. A start sampled outside IDLE SHALL be ignored.
REQ-021 FLUSH: chain_rstn=0 and chain_en=0 for exactly FLUSH_CYCLES cycles, then WARMUP.
REQ-022 WARMUP: chain_rstn=1 and chain_en=1 for exactly WARMUP_CYCLES cycles.
REQ-023 On the WARMUP->MEASURE edge the block SHALL capture base_bits=total_bits and base_err=total_bit_errors.
REQ-024 MEASURE: chain_en=1. The block SHALL compute d_bits=total_bits-base_bits and d_err=total_bit_errors-base_err, both modulo 2^32 so counter wrap is tolerated.
REQ-025 MEASURE exit priority, evaluated each cycle on registered inputs:
  - abort first;
  - then d_bits>=meas_bits, giving status ok;
  - then err_limit!=0 and d_err>=err_limit, giving status early_stop;
  - then the cycle count reaches TIMEOUT_CYCLES, giving status timeout.
  If both the ok and early_stop conditions hold in the same cycle, status SHALL be ok.
REQ-026 On the MEASURE exit cycle the block SHALL latch result_bits=d_bits and result_errors=d_err, then enter DONE.
REQ-027 DONE: lasts exactly one cycle, with done=1, result_valid set, chain_en=0 and chain_rstn=1; then IDLE.
REQ-028 abort high in FLUSH, WARMUP or MEASURE SHALL force IDLE on the next edge: chain_en=0, chain_rstn=1, status=11, result_valid=0, no done pulse.
REQ-029 abort in IDLE or DONE SHALL have no effect. start and abort high together in IDLE SHALL leave the block in IDLE.
REQ-030 meas_bits=0 SHALL complete on the first MEASURE cycle with result_bits equal to the delta observed on that cycle.
REQ-031 Start-to-MEASURE latency SHALL be 1+FLUSH_CYCLES+WARMUP_CYCLES cycles. done SHALL pulse one cycle after the exit condition is observed.
REQ-032 In IDLE, chain_en=0 and chain_rstn=1; the chain is held idle but not in reset.

Reset
REQ-033 rstn low SHALL asynchronously force state=IDLE and set:
  - chain_rstn=0 while rstn is low, 1 after release;
  - chain_en=0, busy=0, done=0;
  - result_bits=0, result_errors=0, result_valid=0;
  - status=00;
  - base and counter registers = 0.
REQ-034 A reset mid-test SHALL discard the test silently; after release the block SHALL sit in IDLE.

Verification (FLUSH_CYCLES=4, WARMUP_CYCLES=8)
REQ-035 Nominal: start at cycle 0, meas_bits=100, checker advancing 1 bit/cycle, no errors. Required: chain_rstn=0 in cycles 1-4; chain_en=1 from cycle 5; done pulse with result_bits=100, result_errors=0, status=00.
REQ-036 Early stop: err_limit=3, errors injected every 10 bits, meas_bits=1000. Required: done with result_errors=3, result_bits≈30, status=01.
REQ-037 Wrap: total_bits forced to 0xFFFFFFF0 at capture, meas_bits=32. Required: done after 32 further bits, result_bits=32.
REQ-038 Timeout: TIMEOUT_CYCLES=16, total_bits frozen. Required: done 16 cycles into MEASURE, status=10, result_bits=0.
REQ-039 Abort: abort asserted in WARMUP cycle 7. Required: IDLE next edge, status=11, no done pulse, result_valid=0; a start issued while busy is ignored.
REQ-040 Async reset asserted mid-MEASURE. Required: all outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/ber_test_sequencer.sv
// BER test sequencer: flushes and warms up the PRBS/DFE chain, then measures bit and
// error deltas from the checker's cumulative counters until done, error limit, timeout or abort.
module ber_test_sequencer #(
  parameter int unsigned FLUSH_CYCLES   = 4,
  parameter int unsigned WARMUP_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] meas_bits_i,
  input  logic [31:0] err_limit_i,
  input  logic [31:0] total_bits_i,
  input  logic [31:0] total_bit_errors_i,
  output logic        chain_rstn_o,
  output logic        chain_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_bits_o,
  output logic [31:0] result_errors_o,
  output logic        result_valid_o,
  output logic [1:0]  status_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_WARMUP,
    S_MEASURE,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_EARLY   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

  localparam logic [31:0] FLUSH_LAST   = 32'(FLUSH_CYCLES - 1);
  localparam logic [31:0] WARMUP_LAST  = 32'(WARMUP_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] meas_q, meas_d;
  logic [31:0] lim_q, lim_d;
  logic [31:0] base_bits_q, base_bits_d;
  logic [31:0] base_err_q, base_err_d;
  logic [31:0] res_bits_q, res_bits_d;
  logic [31:0] res_err_q, res_err_d;
  logic        valid_q, valid_d;
  logic [1:0]  status_q, status_d;
  logic        chain_rstn_q, chain_rstn_d;
  logic        chain_en_q, chain_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] d_bits, d_err;
  logic        stop;

  // Modulo-2^32 deltas tolerate wrap of the checker's free-running counters.
  assign d_bits = total_bits_i - base_bits_q;
  assign d_err  = total_bit_errors_i - base_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    meas_d      = meas_q;
    lim_d       = lim_q;
    base_bits_d = base_bits_q;
    base_err_d  = base_err_q;
    res_bits_d  = res_bits_q;
    res_err_d   = res_err_q;
    valid_d     = valid_q;
    status_d    = status_q;
    stop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
          meas_d  = meas_bits_i;
          lim_d   = err_limit_i;
          valid_d = 1'b0;
        end
      end
      S_FLUSH: begin
        if (abort_i) begin
          stop = 1'b1;
        end else if (cnt_q == FLUSH_LAST) begin
          state_d = S_WARMUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WARMUP: begin
        if (abort_i) begin
          stop = 1'b1;
        end else if (cnt_q == WARMUP_LAST) begin
          state_d     = S_MEASURE;
          cnt_d       = '0;
          base_bits_d = total_bits_i;
          base_err_d  = total_bit_errors_i;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_MEASURE: begin
        if (abort_i) begin
          stop = 1'b1;
        end else begin
          state_d    = S_DONE;
          res_bits_d = d_bits;
          res_err_d  = d_err;
          valid_d    = 1'b1;
          // Bit-count completion outranks the error limit when both hit together.
          if (d_bits >= meas_q) begin
            status_d = ST_OK;
          end else if ((lim_q != '0) && (d_err >= lim_q)) begin
            status_d = ST_EARLY;
          end else if (cnt_q == TIMEOUT_LAST) begin
            status_d = ST_TIMEOUT;
          end else begin
            state_d    = S_MEASURE;
            res_bits_d = res_bits_q;
            res_err_d  = res_err_q;
            valid_d    = valid_q;
            cnt_d      = cnt_q + 32'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d  = S_IDLE;
      status_d = ST_ABORT;
      valid_d  = 1'b0;
    end

    chain_rstn_d = (state_d != S_FLUSH);
    chain_en_d   = (state_d == S_WARMUP) || (state_d == S_MEASURE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      meas_q       <= '0;
      lim_q        <= '0;
      base_bits_q  <= '0;
      base_err_q   <= '0;
      res_bits_q   <= '0;
      res_err_q    <= '0;
      valid_q      <= 1'b0;
      status_q     <= ST_OK;
      chain_rstn_q <= 1'b1;
      chain_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      meas_q       <= meas_d;
      lim_q        <= lim_d;
      base_bits_q  <= base_bits_d;
      base_err_q   <= base_err_d;
      res_bits_q   <= res_bits_d;
      res_err_q    <= res_err_d;
      valid_q      <= valid_d;
      status_q     <= status_d;
      chain_rstn_q <= chain_rstn_d;
      chain_en_q   <= chain_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // The chain follows our own reset while it is asserted and is released with it.
  assign chain_rstn_o    = chain_rstn_q & rstn_i;
  assign chain_en_o      = chain_en_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign result_bits_o   = res_bits_q;
  assign result_errors_o = res_err_q;
  assign result_valid_o  = valid_q;
  assign status_o        = status_q;

endmodule

// File: tb/tb_ber_test_sequencer.sv
// Directed bench for ber_test_sequencer: table of whole-test scenarios plus hand-written
// reset and start/abort corner sequences. Second instance uses a short timeout.
module tb_ber_test_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, abort;
  logic [31:0] meas_bits, err_limit, total_bits, total_errs;

  logic        a_crstn, a_cen, a_busy, a_done, a_valid;
  logic [31:0] a_rbits, a_rerrs;
  logic [1:0]  a_status;
  logic        t_crstn, t_cen, t_busy, t_done, t_valid;
  logic [31:0] t_rbits, t_rerrs;
  logic [1:0]  t_status;

  logic        sel_to = 1'b0;
  logic        s_crstn, s_cen, s_busy, s_done, s_valid;
  logic [31:0] s_rbits, s_rerrs;
  logic [1:0]  s_status;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ber_test_sequencer #(.FLUSH_CYCLES(4), .WARMUP_CYCLES(8)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
    .meas_bits_i(meas_bits), .err_limit_i(err_limit),
    .total_bits_i(total_bits), .total_bit_errors_i(total_errs),
    .chain_rstn_o(a_crstn), .chain_en_o(a_cen), .busy_o(a_busy), .done_o(a_done),
    .result_bits_o(a_rbits), .result_errors_o(a_rerrs),
    .result_valid_o(a_valid), .status_o(a_status)
  );

  ber_test_sequencer #(.FLUSH_CYCLES(4), .WARMUP_CYCLES(8), .TIMEOUT_CYCLES(16)) u_dut_to (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
    .meas_bits_i(meas_bits), .err_limit_i(err_limit),
    .total_bits_i(total_bits), .total_bit_errors_i(total_errs),
    .chain_rstn_o(t_crstn), .chain_en_o(t_cen), .busy_o(t_busy), .done_o(t_done),
    .result_bits_o(t_rbits), .result_errors_o(t_rerrs),
    .result_valid_o(t_valid), .status_o(t_status)
  );

  assign s_crstn  = sel_to ? t_crstn  : a_crstn;
  assign s_cen    = sel_to ? t_cen    : a_cen;
  assign s_busy   = sel_to ? t_busy   : a_busy;
  assign s_done   = sel_to ? t_done   : a_done;
  assign s_valid  = sel_to ? t_valid  : a_valid;
  assign s_rbits  = sel_to ? t_rbits  : a_rbits;
  assign s_rerrs  = sel_to ? t_rerrs  : a_rerrs;
  assign s_status = sel_to ? t_status : a_status;

  typedef struct {
    logic [31:0] init_bits;
    logic [31:0] init_err;
    int          step;        // checker bits per cycle
    int          err_every;   // one error per this many measured bits, 0 = none
    logic [31:0] meas;
    logic [31:0] lim;
    int          abort_cyc;   // -1 = never
    int          restart_cyc; // start pulse while busy, -1 = never
    logic        use_to;
    int          exp_done_cyc;
    logic [1:0]  exp_status;
    logic [31:0] exp_bits;
    logic [31:0] exp_errs;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the cycle in which start is driven; MEASURE begins in cycle 13.
  task automatic run_row(input int idx, input vec_t v);
    int got_done = -1;
    int end_c;
    int bad_cyc = -1;
    logic [1:0]  got_status = 2'b00;
    logic [31:0] got_bits = '0, got_errs = '0;
    logic exp_rstn, exp_en, exp_busy;
    sel_to     = v.use_to;
    start      = 1'b1;
    abort      = 1'b0;
    meas_bits  = v.meas;
    err_limit  = v.lim;
    total_bits = v.init_bits;
    total_errs = v.init_err;
    end_c = (v.exp_done_cyc >= 0) ? v.exp_done_cyc : v.abort_cyc + 1;
    for (int c = 1; c <= 250; c++) begin
      tick();
      start      = (c == v.restart_cyc);
      meas_bits  = (c == v.restart_cyc) ? 32'd7 : v.meas;
      abort      = (c == v.abort_cyc);
      total_bits = v.init_bits + 32'(v.step * c);
      total_errs = v.init_err + ((v.err_every != 0 && c > 12) ? 32'((c - 12) / v.err_every) : 32'd0);
      exp_rstn = !(c >= 1 && c <= 4);
      exp_en   = (c >= 5) && (c < end_c);
      exp_busy = (v.exp_done_cyc >= 0) ? (c <= v.exp_done_cyc) : (c < end_c);
      if (bad_cyc < 0 && (s_crstn !== exp_rstn || s_cen !== exp_en || s_busy !== exp_busy))
        bad_cyc = c;
      if (s_done && got_done < 0) begin
        got_done   = c;
        got_status = s_status;
        got_bits   = s_rbits;
        got_errs   = s_rerrs;
      end
      if (v.exp_done_cyc >= 0 && got_done >= 0 && c == got_done + 1) break;
      if (v.exp_done_cyc < 0 && c == end_c) break;
    end
    start = 1'b0;
    abort = 1'b0;
    $display("row %0d: done_cyc=%0d status=%0d result_bits=%0d result_errors=%0d valid=%0b",
             idx, got_done, got_status, got_bits, got_errs, s_valid);
    chk($sformatf("row%0d phase (first bad cycle)", idx), 32'(bad_cyc), 32'hFFFF_FFFF);
    chk($sformatf("row%0d done cycle", idx), 32'(got_done), 32'(v.exp_done_cyc));
    chk($sformatf("row%0d result_valid", idx), {31'd0, s_valid}, {31'd0, v.exp_valid});
    if (v.exp_done_cyc >= 0) begin
      chk($sformatf("row%0d status", idx), {30'd0, got_status}, {30'd0, v.exp_status});
      chk($sformatf("row%0d result_bits", idx), got_bits, v.exp_bits);
      chk($sformatf("row%0d result_errors", idx), got_errs, v.exp_errs);
    end else begin
      chk($sformatf("row%0d status", idx), {30'd0, s_status}, {30'd0, v.exp_status});
    end
    // Return both instances to IDLE before the next scenario.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    vecs[0] = '{32'd1000, 32'd0, 1, 0, 32'd100, 32'd0, -1, 60, 1'b0, 113, 2'b00, 32'd100, 32'd0, 1'b1};
    vecs[1] = '{32'd5000, 32'd7, 1, 10, 32'd1000, 32'd3, -1, -1, 1'b0, 43, 2'b01, 32'd30, 32'd3, 1'b1};
    vecs[2] = '{32'hFFFF_FFE4, 32'hFFFF_FFFE, 1, 10, 32'd32, 32'd0, -1, -1, 1'b0, 45, 2'b00, 32'd32, 32'd3, 1'b1};
    vecs[3] = '{32'd0, 32'd0, 1, 10, 32'd20, 32'd2, -1, -1, 1'b0, 33, 2'b00, 32'd20, 32'd2, 1'b1};
    vecs[4] = '{32'd0, 32'd0, 1, 0, 32'd0, 32'd0, -1, -1, 1'b0, 14, 2'b00, 32'd1, 32'd0, 1'b1};
    vecs[5] = '{32'd0, 32'd0, 1, 0, 32'd100, 32'd0, 11, 8, 1'b0, -1, 2'b11, 32'd0, 32'd0, 1'b0};
    vecs[6] = '{32'd123, 32'd0, 0, 0, 32'd5, 32'd0, -1, -1, 1'b1, 29, 2'b10, 32'd0, 32'd0, 1'b1};

    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    meas_bits = '0; err_limit = '0; total_bits = '0; total_errs = '0;
    #2;
    chk("reset chain_rstn", {31'd0, a_crstn}, 32'd0);
    chk("reset busy/en/done/valid", {28'd0, a_busy, a_cen, a_done, a_valid}, 32'd0);
    chk("reset status", {30'd0, a_status}, 32'd0);
    chk("reset result_bits", a_rbits, 32'd0);
    #6;
    rstn = 1'b1;
    #1;
    chk("release chain_rstn", {31'd0, a_crstn}, 32'd1);
    tick();

    // start and abort together in IDLE must not launch a test
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start+abort busy", {31'd0, a_busy}, 32'd0);
    tick();
    chk("start+abort busy later", {31'd0, a_busy}, 32'd0);
    $display("seq start+abort in IDLE: busy=%0b", a_busy);

    for (int i = 0; i < 7; i++) run_row(i, vecs[i]);

    // asynchronous reset in the middle of MEASURE
    sel_to = 1'b0;
    start = 1'b1; meas_bits = 32'd1000; err_limit = '0; total_bits = 32'd50;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    chk("mid-measure busy", {31'd0, a_busy}, 32'd1);
    chk("mid-measure chain_en", {31'd0, a_cen}, 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    chk("async rst busy/en/done/valid", {28'd0, a_busy, a_cen, a_done, a_valid}, 32'd0);
    chk("async rst chain_rstn", {31'd0, a_crstn}, 32'd0);
    chk("async rst status", {30'd0, a_status}, 32'd0);
    chk("async rst result_bits", a_rbits, 32'd0);
    $display("seq async reset mid-measure: busy=%0b status=%0d", a_busy, a_status);
    #10;
    rstn = 1'b1;
    tick();
    tick();
    chk("post-reset idle busy", {31'd0, a_busy}, 32'd0);
    chk("post-reset chain_rstn", {31'd0, a_crstn}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
